// File: rtl/hdu_load_use_stall.sv
// Load-use hazard detection unit: compares ID sources against an EX-stage load
// destination and holds PC/IF-ID while bubbling ID/EX for LOAD_LATENCY cycles.
module hdu_load_use_stall #(
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned ZERO_REG_EN  = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_rsrc1,
    input  logic [REG_ADDR_W-1:0] i_rsrc2,
    input  logic                  i_src1_used,
    input  logic                  i_src2_used,
    input  logic [REG_ADDR_W-1:0] i_rdst,
    input  logic                  i_mem_read,
    input  logic                  i_mem_busy,
    input  logic                  i_flush,
    input  logic                  i_cnt_clr,
    output logic                  o_stall,
    output logic                  o_bubble,
    output logic [1:0]            o_hazard_src,
    output logic [CNT_W-1:0]      o_stall_count
);

    localparam int unsigned LAT_W = $clog2(LOAD_LATENCY + 1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             zero_block;
    logic             match1, match2, hazard;
    logic             stall_raw;
    logic [1:0]       src_raw;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        zero_block = (ZERO_REG_EN != 0) && (i_rdst == '0);
        match1     = i_src1_used && (i_rsrc1 == i_rdst) && !zero_block;
        match2     = i_src2_used && (i_rsrc2 == i_rdst) && !zero_block;
        hazard     = i_mem_read && (match1 || match2);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        src_raw   = '0;
        case (state_q)
            IDLE: begin
                src_raw = {match2, match1} & {2{i_mem_read}};
                if (hazard && !i_flush) begin
                    stall_raw = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        state_d = STALL;
                        cnt_d   = LAT_W'(LOAD_LATENCY - 1);
                    end
                end
            end
            STALL: begin
                // EX already holds a bubble here, so new matches are ignored
                stall_raw = 1'b1;
                if (!i_mem_busy) begin
                    if (cnt_q == LAT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - LAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (i_flush) begin
            stall_raw = 1'b0;
            state_d   = IDLE;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_cnt_clr) begin
            count_q <= '0;
        end else if (stall_raw && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Outputs are gated by reset so they read 0 while reset is held
    assign o_stall       = stall_raw & i_rst_n;
    assign o_bubble      = stall_raw & i_rst_n;
    assign o_hazard_src  = src_raw & {2{i_rst_n}};
    assign o_stall_count = count_q;

endmodule

// File: tb/tb_hdu_load_use_stall.sv
// Bench for hdu_load_use_stall: three parameterisations share one stimulus stream
// and are checked against a remaining-stall-cycles reference model.
module tb_hdu_load_use_stall;

    logic       clk;
    logic       rst_n;
    logic [2:0] rsrc1, rsrc2, rdst;
    logic       src1_used, src2_used, mem_read, mem_busy, flush, cnt_clr;

    logic        st[3];
    logic        bb[3];
    logic [1:0]  hs[3];
    logic [15:0] cn[3];
    logic [1:0]  cnt_b;

    int unsigned lat[3]  = '{1, 3, 4};
    int unsigned zr[3]   = '{0, 1, 0};
    int unsigned cmax[3] = '{65535, 3, 65535};

    int unsigned rem[3];
    int unsigned mcount[3];
    logic        e_st[3];
    logic [1:0]  e_hs[3];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    hdu_load_use_stall #(.REG_ADDR_W(3), .LOAD_LATENCY(1), .ZERO_REG_EN(0), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rsrc1(rsrc1), .i_rsrc2(rsrc2),
        .i_src1_used(src1_used), .i_src2_used(src2_used), .i_rdst(rdst),
        .i_mem_read(mem_read), .i_mem_busy(mem_busy), .i_flush(flush), .i_cnt_clr(cnt_clr),
        .o_stall(st[0]), .o_bubble(bb[0]), .o_hazard_src(hs[0]), .o_stall_count(cn[0])
    );

    hdu_load_use_stall #(.REG_ADDR_W(3), .LOAD_LATENCY(3), .ZERO_REG_EN(1), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rsrc1(rsrc1), .i_rsrc2(rsrc2),
        .i_src1_used(src1_used), .i_src2_used(src2_used), .i_rdst(rdst),
        .i_mem_read(mem_read), .i_mem_busy(mem_busy), .i_flush(flush), .i_cnt_clr(cnt_clr),
        .o_stall(st[1]), .o_bubble(bb[1]), .o_hazard_src(hs[1]), .o_stall_count(cnt_b)
    );

    hdu_load_use_stall #(.REG_ADDR_W(3), .LOAD_LATENCY(4), .ZERO_REG_EN(0), .CNT_W(16)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_rsrc1(rsrc1), .i_rsrc2(rsrc2),
        .i_src1_used(src1_used), .i_src2_used(src2_used), .i_rdst(rdst),
        .i_mem_read(mem_read), .i_mem_busy(mem_busy), .i_flush(flush), .i_cnt_clr(cnt_clr),
        .o_stall(st[2]), .o_bubble(bb[2]), .o_hazard_src(hs[2]), .o_stall_count(cn[2])
    );

    assign cn[1] = {14'b0, cnt_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
        end
    endtask

    // Reference: a load-use hazard costs LOAD_LATENCY stall cycles, each busy
    // cycle after the detect cycle adds one more, and flush cancels everything.
    task automatic model_outputs();
        logic m1, m2, hz;
        for (int i = 0; i < 3; i++) begin
            m1 = src1_used && (rsrc1 == rdst) && !(zr[i] == 1 && rdst == 3'd0);
            m2 = src2_used && (rsrc2 == rdst) && !(zr[i] == 1 && rdst == 3'd0);
            hz = mem_read && (m1 || m2);
            if (rem[i] == 0) begin
                e_hs[i] = mem_read ? {m2, m1} : 2'b00;
                e_st[i] = hz && !flush;
            end else begin
                e_hs[i] = 2'b00;
                e_st[i] = !flush;
            end
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 3; i++) begin
            if (flush) rem[i] = 0;
            else if (rem[i] > 0) begin
                if (!mem_busy) rem[i] = rem[i] - 1;
            end else if (e_st[i]) rem[i] = lat[i] - 1;
            if (cnt_clr) mcount[i] = 0;
            else if (e_st[i] && mcount[i] < cmax[i]) mcount[i] = mcount[i] + 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            rem[i]    = 0;
            mcount[i] = 0;
        end
    endtask

    // Called at a falling edge with inputs already driven
    task automatic cycle();
        #1;
        model_outputs();
        for (int i = 0; i < 3; i++) begin
            check("stall", i, 16'(st[i]), 16'(e_st[i]));
            check("bubble", i, 16'(bb[i]), 16'(e_st[i]));
            check("hazard_src", i, 16'(hs[i]), 16'(e_hs[i]));
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("stall_count", i, cn[i], 16'(mcount[i]));
    endtask

    task automatic drive(input logic [2:0] r1, input logic [2:0] r2, input logic u1, input logic u2,
                         input logic [2:0] rd, input logic mr, input logic bz, input logic fl, input logic cl);
        rsrc1 = r1; rsrc2 = r2; src1_used = u1; src2_used = u2; rdst = rd;
        mem_read = mr; mem_busy = bz; flush = fl; cnt_clr = cl;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(3'd1, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_outputs_zero();
        for (int i = 0; i < 3; i++) begin
            check("rst_stall", i, 16'(st[i]), 16'd0);
            check("rst_bubble", i, 16'(bb[i]), 16'd0);
            check("rst_hazard_src", i, 16'(hs[i]), 16'd0);
            check("rst_count", i, cn[i], 16'd0);
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        rsrc1 = 3'd3; rsrc2 = 3'd3; src1_used = 1'b1; src2_used = 1'b1; rdst = 3'd3;
        mem_read = 1'b1; mem_busy = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        #2;
        reset_outputs_zero();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // single hazard on source 1
        drive(3'd3, 3'd6, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        // hazard on source 2
        drive(3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        // hazard with memory busy for two cycles inside the stall
        drive(3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(3'd1, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(3'd1, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);
        // masking cases
        drive(3'd4, 3'd1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(3'd0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        drive(3'd4, 3'd4, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        // busy in idle has no effect
        drive(3'd4, 3'd4, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        // flush on the second stall cycle
        drive(3'd2, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(3'd1, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        // flush in the detect cycle
        drive(3'd2, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        // clear while stalling
        drive(3'd6, 3'd1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(3'd1, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        // asynchronous reset in the middle of a stall
        drive(3'd6, 3'd1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(3'd6, 3'd6, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs_zero();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // randomized traffic over a small register range to provoke matches
        for (int n = 0; n < 400; n++) begin
            drive(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  3'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
